// File: rtl/cbx_param_shadow.sv
// X-direction connection block: CHAN_W tracks pass through, NUM_IPIN pins driven
// by tap muxes whose selects live in an active register loaded from a shadow scan chain.
module cbx_param_shadow #(
   parameter int CHAN_W   = 3,
   parameter int NUM_IPIN = 3,
   parameter int TAPS     = 1
) (
   input  logic                prog_clk,
   input  logic                prog_reset,
   input  logic                ccff_head,
   input  logic                ccff_en,
   input  logic                ccff_commit,
   input  logic [CHAN_W-1:0]   chanx_left_in,
   input  logic [CHAN_W-1:0]   chanx_right_in,
   output logic [CHAN_W-1:0]   chanx_left_out,
   output logic [CHAN_W-1:0]   chanx_right_out,
   output logic [NUM_IPIN-1:0] ipin_out,
   output logic                ccff_tail,
   output logic                cfg_full,
   output logic                cfg_ovf,
   output logic                cfg_valid
);

   localparam int MUX_SIZE = 2 * TAPS;
   localparam int SEL_W    = $clog2(MUX_SIZE + 1);
   localparam int CFG_BITS = NUM_IPIN * SEL_W;
   localparam int CNT_W    = $clog2(CFG_BITS + 1);
   localparam int CAND_W   = 2 ** SEL_W;

   logic [CFG_BITS-1:0] shadow;
   logic [CFG_BITS-1:0] active;
   logic [CNT_W-1:0]    bit_cnt;

   assign chanx_left_out  = chanx_right_in;
   assign chanx_right_out = chanx_left_in;

   assign ccff_tail = shadow[CFG_BITS-1];
   assign cfg_full  = (bit_cnt == CNT_W'(CFG_BITS));

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         shadow    <= '0;
         active    <= '1;
         bit_cnt   <= '0;
         cfg_ovf   <= 1'b0;
         cfg_valid <= 1'b0;
      end else begin
         if (ccff_en) begin
            shadow <= {shadow[CFG_BITS-2:0], ccff_head};
         end
         if (ccff_commit) begin
            // a concurrent shift already counts toward the next load
            active    <= shadow;
            cfg_valid <= cfg_full & ~cfg_ovf;
            cfg_ovf   <= 1'b0;
            bit_cnt   <= ccff_en ? CNT_W'(1) : '0;
         end else if (ccff_en) begin
            if (cfg_full) begin
               cfg_ovf <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
      end
   end

   for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
      logic [SEL_W-1:0]  sel;
      logic [CAND_W-1:0] cand;

      assign sel = active[k*SEL_W +: SEL_W];

      // even selects take the left track, odd the right, taps wrap the channel
      for (genvar s = 0; s < MUX_SIZE; s++) begin : g_tap
         localparam int T = (k + s / 2) % CHAN_W;
         if ((s % 2) == 0) begin : g_l
            assign cand[s] = chanx_left_in[T];
         end else begin : g_r
            assign cand[s] = chanx_right_in[T];
         end
      end

      assign cand[CAND_W-1:MUX_SIZE] = '0;
      assign ipin_out[k] = cand[sel];
   end

endmodule
